// File: rtl/boc_acq_search.sv
// boc_acq_search: Doppler-bin by code-phase acquisition sweep over N_CH correlator channels; BOC_ACQ_EARLY_EXIT_EN stops at first bin meeting threshold.
// Latency: final eop at t -> DECIDE at t+1 -> next LOAD or REPORT at t+2.
// Backpressure: result held in REPORT until rx_res_ready; rx_start ignored while busy.
module boc_acq_search #(
    parameter int N_CH          = 4,
    parameter int CORR_WIDTH    = 32,
    parameter int PRN_PHS_WIDTH = 12,
    parameter int PRN_LEN       = 4092,
    parameter int FCW_WIDTH     = 32,
    parameter int BIN_WIDTH     = 6
) (
    input  logic                       rx_clk,
    input  logic                       rx_rst_n,
    input  logic                       rx_start,
    input  logic [FCW_WIDTH-1:0]       rx_fcw_start,
    input  logic [FCW_WIDTH-1:0]       rx_fcw_step,
    input  logic [BIN_WIDTH-1:0]       rx_bin_num,
    input  logic [CORR_WIDTH-1:0]      rx_thresh,
    input  logic [N_CH*CORR_WIDTH-1:0] rx_corr_acc,
    input  logic [N_CH-1:0]            rx_corr_eop,
    output logic [FCW_WIDTH-1:0]       tx_car_fcw,
    output logic                       tx_corr_rst,
    output logic                       tx_busy,
    output logic                       tx_res_valid,
    input  logic                       rx_res_ready,
    output logic                       tx_res_found,
    output logic [PRN_PHS_WIDTH-1:0]   tx_res_phs,
    output logic [BIN_WIDTH-1:0]       tx_res_bin,
    output logic [CORR_WIDTH-1:0]      tx_res_peak
);
    localparam int CNT_W = $clog2(PRN_LEN + N_CH + 1);

    typedef enum logic [2:0] {IDLE, LOAD, SEARCH, DECIDE, REPORT} state_t;
    state_t state;

    logic [FCW_WIDTH-1:0]     fcw_step;
    logic [BIN_WIDTH-1:0]     bin_last;
    logic [BIN_WIDTH-1:0]     bin_idx;
    logic [CORR_WIDTH-1:0]    thresh;
    logic [CORR_WIDTH-1:0]    best_peak;
    logic [PRN_PHS_WIDTH-1:0] best_phs;
    logic [BIN_WIDTH-1:0]     best_bin;
    logic [CORR_WIDTH-1:0]    bin_peak;
    logic [PRN_PHS_WIDTH-1:0] bin_phs;
    logic [CNT_W-1:0]         eop_cnt;
    logic [PRN_PHS_WIDTH-1:0] phs_cnt [N_CH];

    logic                     win_vld;
    logic [CORR_WIDTH-1:0]    win_val;
    logic [PRN_PHS_WIDTH-1:0] win_phs;
    logic [CNT_W-1:0]         eop_pop;

    // Strict '>' while scanning upward keeps the lowest channel on ties.
    always_comb begin
        win_vld = 1'b0;
        win_val = '0;
        win_phs = '0;
        eop_pop = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (rx_corr_eop[c]) begin
                eop_pop = eop_pop + CNT_W'(1);
                if (!win_vld || rx_corr_acc[c*CORR_WIDTH +: CORR_WIDTH] > win_val) begin
                    win_vld = 1'b1;
                    win_val = rx_corr_acc[c*CORR_WIDTH +: CORR_WIDTH];
                    win_phs = phs_cnt[c];
                end
            end
        end
    end

    logic                     bin_better;
    logic [CORR_WIDTH-1:0]    nxt_peak;
    logic [PRN_PHS_WIDTH-1:0] nxt_phs;
    logic [BIN_WIDTH-1:0]     nxt_bin;
    logic                     nxt_found;
    logic                     early_exit;

    assign bin_better = bin_peak > best_peak;
    assign nxt_peak   = bin_better ? bin_peak : best_peak;
    assign nxt_phs    = bin_better ? bin_phs  : best_phs;
    assign nxt_bin    = bin_better ? bin_idx  : best_bin;
    assign nxt_found  = nxt_peak >= thresh;

`ifdef BOC_ACQ_EARLY_EXIT_EN
    assign early_exit = nxt_found;
`else
    assign early_exit = 1'b0;
`endif

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            state        <= IDLE;
            fcw_step     <= '0;
            bin_last     <= '0;
            bin_idx      <= '0;
            thresh       <= '0;
            best_peak    <= '0;
            best_phs     <= '0;
            best_bin     <= '0;
            bin_peak     <= '0;
            bin_phs      <= '0;
            eop_cnt      <= '0;
            for (int c = 0; c < N_CH; c++) phs_cnt[c] <= '0;
            tx_car_fcw   <= '0;
            tx_corr_rst  <= 1'b0;
            tx_busy      <= 1'b0;
            tx_res_valid <= 1'b0;
            tx_res_found <= 1'b0;
            tx_res_phs   <= '0;
            tx_res_bin   <= '0;
            tx_res_peak  <= '0;
        end else begin
            tx_corr_rst <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_start) begin
                        fcw_step    <= rx_fcw_step;
                        bin_last    <= (rx_bin_num == '0) ? '0 : rx_bin_num - 1'b1;
                        thresh      <= rx_thresh;
                        bin_idx     <= '0;
                        tx_car_fcw  <= rx_fcw_start;
                        best_peak   <= '0;
                        best_phs    <= '0;
                        best_bin    <= '0;
                        tx_busy     <= 1'b1;
                        tx_corr_rst <= 1'b1;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    for (int c = 0; c < N_CH; c++) phs_cnt[c] <= PRN_PHS_WIDTH'(c);
                    bin_peak <= '0;
                    bin_phs  <= '0;
                    eop_cnt  <= '0;
                    state    <= SEARCH;
                end
                SEARCH: begin
                    for (int c = 0; c < N_CH; c++)
                        if (rx_corr_eop[c]) phs_cnt[c] <= phs_cnt[c] + PRN_PHS_WIDTH'(N_CH);
                    if (win_vld && win_val > bin_peak) begin
                        bin_peak <= win_val;
                        bin_phs  <= win_phs;
                    end
                    eop_cnt <= eop_cnt + eop_pop;
                    if (eop_cnt + eop_pop >= CNT_W'(PRN_LEN)) state <= DECIDE;
                end
                DECIDE: begin
                    best_peak <= nxt_peak;
                    best_phs  <= nxt_phs;
                    best_bin  <= nxt_bin;
                    if (early_exit || bin_idx == bin_last) begin
                        tx_res_valid <= 1'b1;
                        tx_res_found <= nxt_found;
                        tx_res_phs   <= nxt_phs;
                        tx_res_bin   <= nxt_bin;
                        tx_res_peak  <= nxt_peak;
                        state        <= REPORT;
                    end else begin
                        bin_idx     <= bin_idx + 1'b1;
                        tx_car_fcw  <= tx_car_fcw + fcw_step;
                        tx_corr_rst <= 1'b1;
                        state       <= LOAD;
                    end
                end
                REPORT: begin
                    if (rx_res_ready) begin
                        tx_res_valid <= 1'b0;
                        tx_busy      <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_boc_acq_search.sv
// Directed bench for boc_acq_search (N_CH=4, PRN_LEN=16); expected results queued at stimulus, checked at tx_res_valid.
module tb_boc_acq_search;
    localparam int N_CH = 4;
    localparam int CW   = 32;
    localparam int PW   = 12;
    localparam int PL   = 16;
    localparam int FW   = 32;
    localparam int BW   = 6;

    logic              rx_clk = 1'b0;
    logic              rx_rst_n = 1'b0;
    logic              rx_start = 1'b0;
    logic [FW-1:0]     rx_fcw_start = '0;
    logic [FW-1:0]     rx_fcw_step = '0;
    logic [BW-1:0]     rx_bin_num = '0;
    logic [CW-1:0]     rx_thresh = '0;
    logic [N_CH*CW-1:0] rx_corr_acc = '0;
    logic [N_CH-1:0]   rx_corr_eop = '0;
    logic              rx_res_ready = 1'b0;
    logic [FW-1:0]     tx_car_fcw;
    logic              tx_corr_rst, tx_busy, tx_res_valid, tx_res_found;
    logic [PW-1:0]     tx_res_phs;
    logic [BW-1:0]     tx_res_bin;
    logic [CW-1:0]     tx_res_peak;

    boc_acq_search #(.N_CH(N_CH), .CORR_WIDTH(CW), .PRN_PHS_WIDTH(PW), .PRN_LEN(PL),
                     .FCW_WIDTH(FW), .BIN_WIDTH(BW)) dut (
        .rx_clk(rx_clk), .rx_rst_n(rx_rst_n), .rx_start(rx_start),
        .rx_fcw_start(rx_fcw_start), .rx_fcw_step(rx_fcw_step), .rx_bin_num(rx_bin_num),
        .rx_thresh(rx_thresh), .rx_corr_acc(rx_corr_acc), .rx_corr_eop(rx_corr_eop),
        .tx_car_fcw(tx_car_fcw), .tx_corr_rst(tx_corr_rst), .tx_busy(tx_busy),
        .tx_res_valid(tx_res_valid), .rx_res_ready(rx_res_ready), .tx_res_found(tx_res_found),
        .tx_res_phs(tx_res_phs), .tx_res_bin(tx_res_bin), .tx_res_peak(tx_res_peak)
    );

    typedef struct packed {
        logic          found;
        logic [PW-1:0] phs;
        logic [BW-1:0] bin;
        logic [CW-1:0] peak;
    } res_t;

    res_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   rst_pulses = 0;

    always #5 rx_clk = ~rx_clk;
    always @(negedge rx_clk) if (tx_corr_rst) rst_pulses++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge rx_clk);
        #1;
    endtask

    task automatic start_search(input logic [FW-1:0] f0, input logic [FW-1:0] st,
                                input logic [BW-1:0] nb, input logic [CW-1:0] th);
        rx_fcw_start = f0;
        rx_fcw_step  = st;
        rx_bin_num   = nb;
        rx_thresh    = th;
        rx_start     = 1'b1;
        tick();
        rx_start     = 1'b0;
    endtask

    // Entered at the LOAD cycle; returns at the cycle after DECIDE.
    task automatic run_bin(input int pch, input int pk, input logic [CW-1:0] pval,
                           input logic [FW-1:0] exp_fcw);
        logic [N_CH*CW-1:0] acc;
        chk("load_corr_rst", tx_corr_rst, 1);
        chk("load_fcw", tx_car_fcw, exp_fcw);
        chk("load_busy", tx_busy, 1);
        rx_corr_eop = 4'b0001;
        rx_corr_acc = {N_CH{CW'(9999)}};
        tick();
        rx_corr_eop = '0;
        chk("corr_rst_one_cycle", tx_corr_rst, 0);
        for (int k = 0; k < PL / N_CH; k++) begin
            for (int c = 0; c < N_CH; c++) begin
                for (int i = 0; i < N_CH; i++)
                    acc[i*CW +: CW] = (i != c) ? CW'(7777) :
                                      (c == pch && k == pk) ? pval : CW'(20 + 4 * k + c);
                rx_corr_acc = acc;
                rx_corr_eop = 4'(1 << c);
                tick();
            end
        end
        rx_corr_eop = '0;
        chk("decide_no_rst", tx_corr_rst, 0);
        chk("decide_no_valid", tx_res_valid, 0);
        tick();
    endtask

    task automatic get_result(input int hold);
        res_t e;
        int   n = 0;
        while (!tx_res_valid && n < 200) begin
            tick();
            n++;
        end
        chk("res_valid_seen", tx_res_valid, 1);
        chk("sb_has_entry", 64'(sb.size() > 0), 1);
        if (!tx_res_valid || sb.size() == 0) return;
        e = sb.pop_front();
        for (int h = 0; h <= hold; h++) begin
            chk("res_found", tx_res_found, e.found);
            chk("res_phs", tx_res_phs, e.phs);
            chk("res_bin", tx_res_bin, e.bin);
            chk("res_peak", tx_res_peak, e.peak);
            if (h < hold) begin
                chk("hold_valid", tx_res_valid, 1);
                chk("hold_busy", tx_busy, 1);
                rx_start = (h % 5 == 2);
                tick();
                rx_start = 1'b0;
            end
        end
        rx_res_ready = 1'b1;
        tick();
        rx_res_ready = 1'b0;
        chk("release_valid", tx_res_valid, 0);
        chk("release_busy", tx_busy, 0);
    endtask

    initial begin
        int p0;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int nbins;
        res_t r;

        // Reset state
        tick();
        tick();
        chk("rst_busy", tx_busy, 0);
        chk("rst_valid", tx_res_valid, 0);
        chk("rst_fcw", tx_car_fcw, 0);
        chk("rst_corr_rst", tx_corr_rst, 0);
        chk("rst_peak", tx_res_peak, 0);
        rx_rst_n = 1'b1;
        tick();

        // Single bin, peak 500 at channel 2's third eop
        r = '{found: 1'b1, phs: PW'(10), bin: BW'(0), peak: CW'(500)};
        sb.push_back(r);
        start_search(FW'(5), FW'(1), BW'(1), CW'(300));
        run_bin(2, 2, CW'(500), FW'(5));
        get_result(0);

        // Three bins, peak only in bin 2, below threshold
        p0 = rst_pulses;
        r = '{found: 1'b0, phs: PW'(13), bin: BW'(2), peak: CW'(900)};
        sb.push_back(r);
        start_search(FW'(100), FW'(10), BW'(3), CW'(1000));
        run_bin(-1, 0, '0, FW'(100));
        run_bin(-1, 0, '0, FW'(110));
        run_bin(1, 3, CW'(900), FW'(120));
        get_result(0);
        chk("three_rst_pulses", rst_pulses - p0, 3);

        // Simultaneous eops 7,9,9,3: channel 1 wins; later equal 9 must not replace
        r = '{found: 1'b1, phs: PW'(1), bin: BW'(0), peak: CW'(9)};
        sb.push_back(r);
        start_search(FW'(0), FW'(0), BW'(1), CW'(5));
        tick();
        rx_corr_eop = 4'b1111;
        rx_corr_acc = {CW'(3), CW'(9), CW'(9), CW'(7)};
        tick();
        rx_corr_acc = {CW'(9), CW'(0), CW'(0), CW'(0)};
        tick();
        rx_corr_acc = {N_CH{CW'(1)}};
        tick();
        tick();
        rx_corr_eop = '0;
        chk("all_eop_decide", tx_res_valid, 0);
        tick();
        chk("all_eop_report", tx_res_valid, 1);
        get_result(0);

        // Equal peaks in bins 1 and 2
        p0 = rst_pulses;
        r = '{found: 1'b1, phs: PW'(4), bin: BW'(1), peak: CW'(800)};
        sb.push_back(r);
        start_search(FW'(7), FW'(3), BW'(3), CW'(500));
        run_bin(-1, 0, '0, FW'(7));
        run_bin(0, 1, CW'(800), FW'(10));
`ifdef BOC_ACQ_EARLY_EXIT_EN
        nbins = 2;
`else
        nbins = 3;
        run_bin(3, 0, CW'(800), FW'(13));
`endif
        get_result(0);
        chk("bins_loaded", rst_pulses - p0, nbins);

        // rx_bin_num=0 acts as 1; peak equal to threshold; 20-cycle hold with start pulses
        r = '{found: 1'b1, phs: PW'(3), bin: BW'(0), peak: CW'(400)};
        sb.push_back(r);
        start_search(FW'(1), FW'(1), BW'(0), CW'(400));
        run_bin(3, 0, CW'(400), FW'(1));
        get_result(20);
        tick();
        chk("no_restart_busy", tx_busy, 0);
        chk("no_restart_corr_rst", tx_corr_rst, 0);

        // Reset mid-search abandons it
        start_search(FW'(55), FW'(1), BW'(2), CW'(0));
        tick();
        rx_corr_eop = 4'b0011;
        rx_corr_acc = {N_CH{CW'(50)}};
        tick();
        tick();
        rx_corr_eop = '0;
        chk("mid_busy", tx_busy, 1);
        rx_rst_n = 1'b0;
        #1;
        chk("arst_busy", tx_busy, 0);
        chk("arst_valid", tx_res_valid, 0);
        chk("arst_fcw", tx_car_fcw, 0);
        chk("arst_peak", tx_res_peak, 0);
        tick();
        rx_rst_n = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        chk("post_rst_valid", tx_res_valid, 0);
        chk("post_rst_busy", tx_busy, 0);
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
